// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x-oversampling baud generator, 2-FF synchroniser and error strobes
// Ports: clk, reset (sync, active-high), rx (async serial line, idles high),
//   dout (last good byte), rx_done_tick / frame_err (one-cycle strobes),
//   s_tick (oversample tick, one clk wide), parity_err (strobe, only with UART_RX_PARITY_EN).
// Optional: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int BAUD_DIV = 326
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            s_tick
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(DBIT);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [BW-1:0] baud_q;
  logic tick, rx_m_q, rx_s_q, par_bad;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [NW-1:0] n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d, dout_q, dout_d;
  logic done_q, done_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign par_bad = ^{b_q, par_q};
`else
  assign par_bad = 1'b0;
`endif
  assign tick = baud_q == BW'(BAUD_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q <= '0;
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      baud_q <= tick ? '0 : baud_q + BW'(1);
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        s_cnt_d = '0;
      end
      START: if (tick) begin
        if (s_cnt_q == 4'd7) begin
          state_d = rx_s_q ? IDLE : DATA;
          s_cnt_d = '0;
          n_cnt_d = '0;
        end else s_cnt_d = s_cnt_q + 4'd1;
      end
      DATA: if (tick) begin
        if (s_cnt_q == 4'd15) begin
          b_d     = {rx_s_q, b_q[DBIT-1:1]};
          s_cnt_d = '0;
          n_cnt_d = n_cnt_q + NW'(1);
`ifdef UART_RX_PARITY_EN
          if (n_cnt_q == NW'(DBIT - 1)) state_d = PARITY;
`else
          if (n_cnt_q == NW'(DBIT - 1)) state_d = STOP;
`endif
        end else s_cnt_d = s_cnt_q + 4'd1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        if (s_cnt_q == 4'd15) begin
          par_d   = rx_s_q;
          s_cnt_d = '0;
          state_d = STOP;
        end else s_cnt_d = s_cnt_q + 4'd1;
      end
`endif
      STOP: if (tick) begin
        if (s_cnt_q == 4'(SB_TICK - 1)) begin
          state_d = IDLE;
          s_cnt_d = '0;
          done_d  = rx_s_q & ~par_bad;
          ferr_d  = ~rx_s_q;
          dout_d  = (rx_s_q & ~par_bad) ? b_q : dout_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = rx_s_q & par_bad;
`endif
        end else s_cnt_d = s_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dout         = dout_q;
    rx_done_tick = done_q;
    frame_err    = ferr_q;
    s_tick       = tick;
`ifdef UART_RX_PARITY_EN
    parity_err   = perr_q;
`endif
  end
endmodule
